vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter MAP_LATENCY, default 1: clk_vga cycles from a CurrentX/CurrentY value to the matching mapData; legal range 1..4.
REQ-002 clk_vga  input  1  pixel clock, 25.175 MHz nominal; all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mapData  input  8  map colour, RRRGGGBB, valid MAP_LATENCY cycles after its coordinates.
REQ-005 CurrentX  output  10  registered horizontal count hcnt, 0..799.
REQ-006 CurrentY  output  9  registered vcnt[8:0]; vcnt is 10-bit internal, 0..524.
REQ-007 Hsync  output  1  horizontal sync, active low.
REQ-008 Vsync  output  1  vertical sync, active low.
REQ-009 Red  output  3  mapData[7:5] when active, else 0.
REQ-010 Green  output  3  mapData[4:2] when active, else 0.
REQ-011 Blue  output  2  mapData[1:0] when active, else 0.
REQ-012 frameTick  output  1  one-cycle pulse at the start of vertical blank.

Function
REQ-013 hcnt SHALL increment by 1 each cycle and wrap 799 -> 0.
REQ-014 vcnt SHALL increment by 1 only on the cycle hcnt wraps, and SHALL wrap 524 -> 0 when hcnt also wraps.
REQ-015 CurrentX SHALL equal hcnt and CurrentY SHALL equal vcnt[8:0]; during vcnt 480..524 CurrentY values are defined but carry no map meaning.
REQ-016 active SHALL be (hcnt < 640) and (vcnt < 480).
REQ-017 hs_raw SHALL be low for hcnt 656..751 inclusive and high otherwise.
REQ-018 vs_raw SHALL be low for vcnt 490..491 inclusive and high otherwise.
REQ-019 active, hs_raw and vs_raw SHALL pass through a MAP_LATENCY+1 stage register delay line.
REQ-020 Red/Green/Blue SHALL be registered from mapData gated by the active bit at delay MAP_LATENCY.
REQ-021 Together, REQ-019 and REQ-020 SHALL make Hsync, Vsync and RGB for coordinate (x,y) appear MAP_LATENCY+1 cycles after CurrentX=x, CurrentY=y.
REQ-022 RGB SHALL be 0 whenever the delayed active bit is 0, regardless of mapData.
REQ-023 frameTick SHALL be 1 for exactly the single cycle in which CurrentX=0 and vcnt=480, undelayed.
REQ-024 Total period SHALL be 800 x 525 = 420000 cycles per frame.
REQ-025 Hsync low width SHALL be exactly 96 cycles and Vsync low width exactly 2 lines (1600 cycles).
REQ-026 Outputs SHALL change only on rising clk_vga, except on reset assertion.

Reset
REQ-027 While reset is high: hcnt=0, vcnt=0, CurrentX=0, CurrentY=0, Hsync=1, Vsync=1, RGB=0, frameTick=0, and every delay-line stage holds active=0, hs=1, vs=1.
REQ-028 Reset assertion mid-line or mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-029 On the first rising edge after reset deasserts, hcnt SHALL advance 0 -> 1.
REQ-030 After reset deasserts, Hsync, Vsync and RGB SHALL stay at their reset values until valid data propagates through the delay line.

Verification
REQ-031 Release reset, run 420000 cycles -> CurrentX/CurrentY return to 0/0 exactly at cycle 420000; frameTick pulses once, at cycle 800*480 = 384000.
REQ-032 MAP_LATENCY=1, stub map registers mapData = CurrentX[7:0] -> at CurrentX=10 the cycle-2 output {Red,Green,Blue} = 8'h0A; at CurrentX=640 the output two cycles later is RGB=0.
REQ-033 Count one line from reset -> Hsync falls at the cycle 2 after hcnt=656 and rises at the cycle 2 after hcnt=752, giving 96 low cycles; Vsync low for exactly 1600 cycles per frame.
REQ-034 Drive mapData=8'hFF constantly -> RGB nonzero only during 640x480 active pixels: 307200 nonzero cycles per frame.
REQ-035 Assert reset asynchronously at hcnt=700, vcnt=490, between clock edges -> outputs take reset values before the next edge; after release the frame restarts at 0/0.
REQ-036 MAP_LATENCY=3 with stub delay 3 -> RGB/sync alignment offset is 4 cycles; REQ-032 checks repeated with shifted timing.

Source files
------------

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 scan generator; sync and colour delayed to line up with map lookup latency.
module vga_scan_gen #(
    parameter int MAP_LATENCY = 1,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic [7:0] mapData,
    output logic [9:0] CurrentX,
    output logic [8:0] CurrentY,
    output logic       Hsync,
    output logic       Vsync,
    output logic [2:0] Red,
    output logic [2:0] Green,
    output logic [1:0] Blue,
    output logic       frameTick
);
    localparam int D = MAP_LATENCY + 1;
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [D-1:0] act_q, act_d, hs_q, hs_d, vs_q, vs_d;
    logic [7:0]   rgb_q, rgb_d;
    logic         tick_q, tick_d, h_wrap;

    always_comb begin
        h_wrap = hcnt_q == H_LAST;
        hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d = !h_wrap ? vcnt_q : (vcnt_q == V_LAST ? 10'd0 : vcnt_q + 10'd1);
        // Stage 0 samples the raw decode of the current coordinate; stage D-1 drives the pins.
        act_d  = {act_q[D-2:0], (hcnt_q < H_ACT) && (vcnt_q < V_ACT)};
        hs_d   = {hs_q[D-2:0], !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END))};
        vs_d   = {vs_q[D-2:0], !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END))};
        // mapData belongs to the coordinate whose active bit sits in stage MAP_LATENCY-1.
        rgb_d  = act_q[MAP_LATENCY-1] ? mapData : 8'h00;
        tick_d = (hcnt_d == 10'd0) && (vcnt_d == V_ACT);
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            act_q  <= '0;
            hs_q   <= '1;
            vs_q   <= '1;
            rgb_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            act_q  <= act_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
            tick_q <= tick_d;
        end
    end

    assign CurrentX  = hcnt_q;
    assign CurrentY  = vcnt_q[8:0];
    assign Hsync     = hs_q[D-1];
    assign Vsync     = vs_q[D-1];
    assign Red       = rgb_q[7:5];
    assign Green     = rgb_q[4:2];
    assign Blue      = rgb_q[1:0];
    assign frameTick = tick_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: full-size timing at MAP_LATENCY=1 and a short-frame instance at MAP_LATENCY=3,
// each checked cycle by cycle against a scoreboard of expected pixels.
module tb_vga_scan_gen;
    logic       clk = 1'b0, reset = 1'b1;
    bit         run = 0, ff = 0;
    int         n_checks = 0, n_errors = 0;

    logic [9:0] cx_a, cx_b;
    logic [8:0] cy_a, cy_b;
    logic       hs_a, vs_a, ft_a, hs_b, vs_b, ft_b;
    logic [2:0] r_a, g_a, r_b, g_b;
    logic [1:0] b_a, b_b;
    logic [7:0] ma1, mb1, mb2, mb3, md_a, md_b;

    always #5 clk = ~clk;

    vga_scan_gen #(.MAP_LATENCY(1)) dut_a (
        .clk_vga(clk), .reset(reset), .mapData(md_a), .CurrentX(cx_a), .CurrentY(cy_a),
        .Hsync(hs_a), .Vsync(vs_a), .Red(r_a), .Green(g_a), .Blue(b_a), .frameTick(ft_a));

    vga_scan_gen #(.MAP_LATENCY(3), .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_b (
        .clk_vga(clk), .reset(reset), .mapData(md_b), .CurrentX(cx_b), .CurrentY(cy_b),
        .Hsync(hs_b), .Vsync(vs_b), .Red(r_b), .Green(g_b), .Blue(b_b), .frameTick(ft_b));

    // Map stubs: registered lookup of CurrentX[7:0] with 1 and 3 cycles of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ma1 <= '0; mb1 <= '0; mb2 <= '0; mb3 <= '0;
        end else begin
            ma1 <= cx_a[7:0]; mb1 <= cx_b[7:0]; mb2 <= mb1; mb3 <= mb2;
        end
    end
    assign md_a = ff ? 8'hFF : ma1;
    assign md_b = ff ? 8'hFF : mb3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] pix(input int x, input int y, input int va, input int vs0, input bit f);
        logic       h, v, act;
        logic [7:0] c;
        h   = !(x >= 656 && x <= 751);
        v   = !(y >= vs0 && y <= vs0 + 1);
        act = x < 640 && y < va;
        c   = f ? 8'hFF : 8'(x);
        return {h, v, act ? c : 8'h00};
    endfunction

    logic [9:0] qa[$], qb[$], ea, eb;
    int hm_a, vm_a, hm_b, vm_b, hlow, vlow, ticks, nz;
    logic prev_hs;

    task automatic start();
        @(posedge clk);
        #1 reset = 1'b0;
        hm_a = 0; vm_a = 0; hm_b = 0; vm_b = 0;
        hlow = 0; vlow = 0; ticks = 0; nz = 0; prev_hs = 1'b1;
        qa.delete(); qb.delete();
        repeat (2) qa.push_back(10'h300);
        repeat (4) qb.push_back(10'h300);
        run = 1;
    endtask

    task automatic check_reset_outputs();
        check("rst_x_a", cx_a, 0);  check("rst_y_a", cy_a, 0);
        check("rst_hs_a", hs_a, 1); check("rst_vs_a", vs_a, 1);
        check("rst_rgb_a", {r_a, g_a, b_a}, 0); check("rst_tick_a", ft_a, 0);
        check("rst_x_b", cx_b, 0);  check("rst_y_b", cy_b, 0);
        check("rst_hs_b", hs_b, 1); check("rst_vs_b", vs_b, 1);
        check("rst_rgb_b", {r_b, g_b, b_b}, 0); check("rst_tick_b", ft_b, 0);
    endtask

    always @(negedge clk) if (run) begin
        check("a_x", cx_a, hm_a);
        check("a_y", cy_a, vm_a % 512);
        check("a_tick", ft_a, hm_a == 0 && vm_a == 480);
        qa.push_back(pix(hm_a, vm_a, 480, 490, ff));
        ea = qa.pop_front();
        check("a_pix", {hs_a, vs_a, r_a, g_a, b_a}, ea);
        if (!hs_a) hlow++;
        if (prev_hs && !hs_a) check("a_hs_fall_x", hm_a, 658);
        if (!prev_hs && hs_a) check("a_hs_rise_x", hm_a, 754);
        prev_hs = hs_a;
        if (hm_a == 799) begin
            check("a_hs_width", hlow, 96);
            hlow = 0;
        end
        hm_a++;
        if (hm_a == 800) begin hm_a = 0; vm_a = (vm_a == 524) ? 0 : vm_a + 1; end
    end

    always @(negedge clk) if (run) begin
        check("b_x", cx_b, hm_b);
        check("b_y", cy_b, vm_b);
        check("b_tick", ft_b, hm_b == 0 && vm_b == 4);
        qb.push_back(pix(hm_b, vm_b, 4, 6, ff));
        eb = qb.pop_front();
        check("b_pix", {hs_b, vs_b, r_b, g_b, b_b}, eb);
        if (!vs_b) vlow++;
        if (ft_b) ticks++;
        if ({r_b, g_b, b_b} != 8'h00) nz++;
        if (hm_b == 799 && vm_b == 10) begin
            check("b_vs_low_cycles", vlow, 1600);
            check("b_ticks_per_frame", ticks, 1);
            if (ff) check("b_nonzero_rgb", nz, 2560);
            vlow = 0; ticks = 0; nz = 0;
        end
        hm_b++;
        if (hm_b == 800) begin hm_b = 0; vm_b = (vm_b == 10) ? 0 : vm_b + 1; end
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #2 check_reset_outputs();
        start();
        repeat (9000) @(posedge clk);
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(posedge clk);
            #2 found = (hm_b == 700 && vm_b == 6);
        end
        check("b_reach_sync_line", found, 1);
        check("b_vs_low_before_reset", vs_b, 0);
        reset = 1'b1;
        run = 0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #2 check_reset_outputs();
        ff = 1;
        start();
        repeat (9000) @(posedge clk);
        #2 run = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
